sdcard_ram_writer: RTL and testbench

Downstream stage of the SD-card boot loader. It accepts the byte stream read off the card through a valid/ready handshake and packs each group of four bytes big-endian into a 32-bit word. It writes 64-word (256-byte) bursts into the memory-controller write port and reports progress, done and error to the boot/status logic.

---
 rtl/sdcard_defs_pkg.sv | 28 ++
 rtl/sdcard_ram_writer_packer.sv | 54 +++++
 rtl/sdcard_ram_writer.sv | 209 ++++++++++++++++++++
 tb/tb_sdcard_ram_writer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdcard_defs (package)
//  Description : Definitions shared by the SD-card reader and RAM writer:
//                memory-controller command constants, burst geometry and the
//                writer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdcard_defs;

    // Memory-controller command encoding and burst geometry
    localparam logic [2:0] MEM_CMD_WRITE   = 3'b000;
    localparam int         MEM_BURST_WORDS = 64;
    localparam int         MEM_BURST_BYTES = 256;
    localparam logic [5:0] MEM_BL          = 6'd63;

    // RAM writer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_CMD   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sdcard_ram_writer_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_packer
//  Description : Packs four consecutive bytes big-endian into a 32-bit word.
//                The byte position is supplied by the caller; when the byte in
//                position 3 is taken, the completed word is registered and
//                word_valid_o pulses for exactly one cycle.
//  Ports       : clk, rst_n       - clock, asynchronous active-low reset
//                byte_valid_i     - byte_i is taken this cycle
//                byte_i [7:0]     - incoming byte
//                byte_idx_i [1:0] - position of byte_i within the word
//                word_o [31:0]    - last completed word (held between pulses)
//                word_valid_o     - one-cycle pulse per completed word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  byte_idx_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    // Holds the first three bytes of the word under construction, oldest in
    // the top byte, so the fourth byte completes {b0,b1,b2,b3} directly.
    logic [23:0] shift_q;
    logic [31:0] word_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_valid_i) begin
                if (byte_idx_i == 2'd3) begin
                    word_q  <= {shift_q, byte_i};
                    valid_q <= 1'b1;
                end else begin
                    shift_q <= {shift_q[15:0], byte_i};
                end
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/sdcard_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : sdcard_ram_writer
//  Description : Accepts the card byte stream, packs it into 32-bit words and
//                writes 64-word bursts to the memory-controller write port,
//                issuing one write command per burst. Reports progress, done
//                and controller faults.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                start_i                    - begin a copy (IDLE only)
//                in_data_i/in_valid_i/in_ready_o - byte stream handshake
//                mem_cmd_*                  - controller command port
//                mem_wr_*                   - controller write-data port
//                done_o, error_o            - sticky status
//                progress_o [7:0]           - fraction complete, 0..255
//  Revision    : 1.0 - initial release
// ============================================================================
module sdcard_ram_writer
    import sdcard_defs::*;
#(
    parameter int          TOTAL_BYTES = 65536,
    parameter logic [29:0] BASE_ADDR   = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        mem_cmd_en_o,
    output logic [2:0]  mem_cmd_instr_o,
    output logic [5:0]  mem_cmd_bl_o,
    output logic [29:0] mem_cmd_byte_addr_o,
    input  logic        mem_cmd_empty_i,
    input  logic        mem_cmd_full_i,
    output logic        mem_wr_en_o,
    output logic [3:0]  mem_wr_mask_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_wr_full_i,
    input  logic        mem_wr_empty_i,
    input  logic [6:0]  mem_wr_count_i,
    input  logic        mem_wr_underrun_i,
    input  logic        mem_wr_error_i,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  progress_o
);

    // Completed-byte counter must reach TOTAL_BYTES itself, hence one extra bit.
    localparam int CW    = $clog2(TOTAL_BYTES) + 1;
    localparam int SHIFT = $clog2(TOTAL_BYTES) - 8;

    state_t          state_q, state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [5:0]      word_cnt_q, word_cnt_d;
    logic [29:0]     burst_addr_q, burst_addr_d;
    logic [CW-1:0]   completed_q, completed_d;
    logic            cmd_en_q, cmd_en_d;
    logic [29:0]     cmd_addr_q, cmd_addr_d;
    logic [7:0]      progress_q, progress_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_fault;
    logic            w_fault_state;
    logic [CW-1:0]   w_completed_next;
    logic [CW-1:0]   w_prog_shift;
    logic            w_last;
    logic [31:0]     w_word;
    logic            w_word_valid;
    logic            w_unused;

    assign w_in_ready       = (state_q == ST_FILL) && !mem_wr_full_i;
    assign w_accept         = w_in_ready && in_valid_i;
    assign w_fault          = mem_wr_underrun_i || mem_wr_error_i;
    assign w_fault_state    = (state_q == ST_FILL) || (state_q == ST_CMD) ||
                              (state_q == ST_FLUSH);
    assign w_completed_next = completed_q + CW'(MEM_BURST_BYTES);
    assign w_prog_shift     = w_completed_next >> SHIFT;
    assign w_last           = (w_completed_next == CW'(TOTAL_BYTES));

    // Occupancy is for debug visibility only; upper progress bits are the
    // saturated-away part of the fraction.
    assign w_unused = ^{mem_wr_count_i, w_prog_shift[CW-1:8]};

    byte_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (w_accept),
        .byte_i       (in_data_i),
        .byte_idx_i   (byte_idx_q),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_cnt_d   = word_cnt_q;
        burst_addr_d = burst_addr_q;
        completed_d  = completed_q;
        cmd_en_d     = 1'b0;
        cmd_addr_d   = cmd_addr_q;
        progress_d   = progress_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_FILL;
                    burst_addr_d = BASE_ADDR;
                    byte_idx_d   = 2'd0;
                    word_cnt_d   = 6'd0;
                    completed_d  = '0;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        word_cnt_d = word_cnt_q + 6'd1;
                        if (word_cnt_q == 6'(MEM_BURST_WORDS - 1)) begin
                            state_d = ST_CMD;
                        end
                    end
                end
            end
            ST_CMD: begin
                if (!mem_cmd_full_i) begin
                    cmd_en_d     = 1'b1;
                    cmd_addr_d   = burst_addr_q;
                    burst_addr_d = burst_addr_q + 30'(MEM_BURST_BYTES);
                    completed_d  = w_completed_next;
                    // The full-scale value does not fit 8 bits; report it
                    // as FF rather than letting it wrap to 0.
                    progress_d   = w_last ? 8'hFF : w_prog_shift[7:0];
                    word_cnt_d   = 6'd0;
                    state_d      = w_last ? ST_FLUSH : ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (mem_wr_empty_i && mem_cmd_empty_i) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    progress_d = 8'hFF;
                end
            end
            ST_DONE, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A controller fault overrides whatever transition was chosen above.
        if (w_fault && w_fault_state) begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            cmd_en_d   = 1'b0;
            cmd_addr_d = cmd_addr_q;
            progress_d = progress_q;
            done_d     = done_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= 2'd0;
            word_cnt_q   <= 6'd0;
            burst_addr_q <= '0;
            completed_q  <= '0;
            cmd_en_q     <= 1'b0;
            cmd_addr_q   <= '0;
            progress_q   <= 8'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            word_cnt_q   <= word_cnt_d;
            burst_addr_q <= burst_addr_d;
            completed_q  <= completed_d;
            cmd_en_q     <= cmd_en_d;
            cmd_addr_q   <= cmd_addr_d;
            progress_q   <= progress_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready_o          = w_in_ready;
    assign mem_cmd_en_o        = cmd_en_q;
    assign mem_cmd_instr_o     = MEM_CMD_WRITE;
    assign mem_cmd_bl_o        = MEM_BL;
    assign mem_cmd_byte_addr_o = cmd_addr_q;
    // A word completed in the same cycle a fault is seen must not reach RAM.
    assign mem_wr_en_o         = w_word_valid && (state_q != ST_ERROR);
    assign mem_wr_mask_o       = 4'b0000;
    assign mem_wr_data_o       = w_word;
    assign done_o              = done_q;
    assign error_o             = error_q;
    assign progress_o          = progress_q;

endmodule
`default_nettype wire

// File: tb/tb_sdcard_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdcard_ram_writer
//  Description : Self-checking bench for sdcard_ram_writer (1 KiB copy at
//                0x1000). A transaction-level model tracks accepted bytes,
//                expected words, burst commands and status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdcard_ram_writer;

    localparam int          TOTAL  = 1024;
    localparam logic [29:0] BASE   = 30'h1000;
    localparam int          BURSTS = TOTAL / 256;
    localparam int P_IDLE = 0, P_FILL = 1, P_CMD = 2, P_FLUSH = 3, P_DONE = 4, P_ERR = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  in_data_i = 8'd0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        mem_cmd_en_o;
    logic [2:0]  mem_cmd_instr_o;
    logic [5:0]  mem_cmd_bl_o;
    logic [29:0] mem_cmd_byte_addr_o;
    logic        mem_cmd_empty_i = 1'b1;
    logic        mem_cmd_full_i = 1'b0;
    logic        mem_wr_en_o;
    logic [3:0]  mem_wr_mask_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_wr_full_i = 1'b0;
    logic        mem_wr_empty_i = 1'b1;
    logic [6:0]  mem_wr_count_i = 7'd0;
    logic        mem_wr_underrun_i = 1'b0;
    logic        mem_wr_error_i = 1'b0;
    logic        done_o;
    logic        error_o;
    logic [7:0]  progress_o;

    sdcard_ram_writer #(.TOTAL_BYTES(TOTAL), .BASE_ADDR(BASE)) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .in_data_i           (in_data_i),
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .mem_cmd_en_o        (mem_cmd_en_o),
        .mem_cmd_instr_o     (mem_cmd_instr_o),
        .mem_cmd_bl_o        (mem_cmd_bl_o),
        .mem_cmd_byte_addr_o (mem_cmd_byte_addr_o),
        .mem_cmd_empty_i     (mem_cmd_empty_i),
        .mem_cmd_full_i      (mem_cmd_full_i),
        .mem_wr_en_o         (mem_wr_en_o),
        .mem_wr_mask_o       (mem_wr_mask_o),
        .mem_wr_data_o       (mem_wr_data_o),
        .mem_wr_full_i       (mem_wr_full_i),
        .mem_wr_empty_i      (mem_wr_empty_i),
        .mem_wr_count_i      (mem_wr_count_i),
        .mem_wr_underrun_i   (mem_wr_underrun_i),
        .mem_wr_error_i      (mem_wr_error_i),
        .done_o              (done_o),
        .error_o             (error_o),
        .progress_o          (progress_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            phase;
    int            cyc = 0;
    byte unsigned  stream[$];
    byte unsigned  acc[$];
    logic [31:0]   exp_words[$];
    int            sent, burst_bytes, cmds_model, cmds_seen;
    bit            exp_wr, exp_cmd;
    // Stimulus knobs
    int            valid_pct, wf_start, wf_len, cmdfull_len, cmd_hold, flush_len, flush_hold;
    bit            start_req, err_req;
    // Observations of DUT activity
    int            dut_wr, dut_cmds;
    logic [31:0]   first_data, last_data;
    logic [29:0]   first_cmd_addr;

    task automatic model_clear();
        phase = P_IDLE;
        acc.delete();
        exp_words.delete();
        sent = 0; burst_bytes = 0; cmds_model = 0; cmds_seen = 0;
        exp_wr = 1'b0; exp_cmd = 1'b0;
        cmd_hold = 0; flush_hold = 0;
        start_req = 1'b0; err_req = 1'b0;
        dut_wr = 0; dut_cmds = 0;
        first_data = '0; last_data = '0; first_cmd_addr = '0;
    endtask

    task automatic load_stream(input bit counting);
        stream.delete();
        for (int i = 0; i < TOTAL; i++)
            stream.push_back(counting ? 8'(i) : 8'($urandom));
    endtask

    // One clock of stimulus: check what the DUT shows now, drive the next
    // inputs, then advance the model across the coming edge.
    task automatic run_cycle();
        logic [31:0] w;
        int          p;
        bit          exp_ready;
        bit          acc_now;
        @(negedge clk);
        cyc++;
        if (mem_wr_en_o === 1'b1) begin
            if (dut_wr == 0) first_data = mem_wr_data_o;
            last_data = mem_wr_data_o;
            dut_wr++;
        end
        if (mem_cmd_en_o === 1'b1) begin
            if (dut_cmds == 0) first_cmd_addr = mem_cmd_byte_addr_o;
            dut_cmds++;
        end
        n_tests++;
        if (mem_wr_en_o !== exp_wr) begin
            n_fail++;
            $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, mem_wr_en_o, exp_wr);
        end
        if (exp_wr) begin
            w = exp_words.pop_front();
            n_tests++;
            if (mem_wr_data_o !== w) begin
                n_fail++;
                $display("FAIL wr_data cyc=%0d got=%h exp=%h", cyc, mem_wr_data_o, w);
            end
        end
        n_tests++;
        if (mem_cmd_en_o !== exp_cmd) begin
            n_fail++;
            $display("FAIL cmd_en cyc=%0d got=%b exp=%b", cyc, mem_cmd_en_o, exp_cmd);
        end
        if (exp_cmd) begin
            n_tests++;
            if (mem_cmd_byte_addr_o !== BASE + 30'(256 * cmds_seen)) begin
                n_fail++;
                $display("FAIL cmd_addr cyc=%0d got=%h exp=%h", cyc, mem_cmd_byte_addr_o,
                         BASE + 30'(256 * cmds_seen));
            end
            cmds_seen++;
            p = (cmds_seen * 256 * 256) / TOTAL;
            if (p > 255) p = 255;
            if (cmds_seen < BURSTS) begin
                n_tests++;
                if (progress_o !== 8'(p)) begin
                    n_fail++;
                    $display("FAIL progress cyc=%0d got=%0d exp=%0d", cyc, progress_o, p);
                end
            end
        end
        n_tests++;
        if (done_o !== (phase == P_DONE)) begin
            n_fail++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, phase == P_DONE);
        end
        n_tests++;
        if (error_o !== (phase == P_ERR)) begin
            n_fail++;
            $display("FAIL error cyc=%0d got=%b exp=%b", cyc, error_o, phase == P_ERR);
        end
        if (phase == P_DONE) begin
            n_tests++;
            if (progress_o !== 8'hFF) begin
                n_fail++;
                $display("FAIL progress_done cyc=%0d got=%h exp=ff", cyc, progress_o);
            end
        end

        // Drive next inputs
        mem_wr_full_i  = (cyc >= wf_start) && (cyc < wf_start + wf_len);
        mem_cmd_full_i = 1'b0;
        if (phase == P_CMD && cmd_hold > 0) begin
            mem_cmd_full_i = 1'b1;
            cmd_hold--;
        end
        mem_wr_empty_i  = 1'b1;
        mem_cmd_empty_i = 1'b1;
        if (phase == P_FLUSH && flush_hold > 0) begin
            mem_wr_empty_i = 1'b0;
            if (flush_hold % 2 == 1) mem_cmd_empty_i = 1'b0;
            flush_hold--;
        end else if (phase == P_FILL) begin
            mem_wr_empty_i = 1'b0;
        end
        mem_wr_count_i = 7'($urandom_range(64));
        start_i        = start_req;
        start_req      = 1'b0;
        mem_wr_error_i = err_req;
        err_req        = 1'b0;
        if (phase == P_FILL) begin
            if (sent < stream.size() && $urandom_range(99) < valid_pct) begin
                in_valid_i = 1'b1;
                in_data_i  = stream[sent];
            end else begin
                in_valid_i = 1'b0;
                in_data_i  = 8'($urandom);
            end
        end else begin
            in_valid_i = 1'($urandom_range(1));
            in_data_i  = 8'($urandom);
        end
        #1;
        exp_ready = (phase == P_FILL) && !mem_wr_full_i;
        n_tests++;
        if (in_ready_o !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready_o, exp_ready);
        end
        acc_now = in_valid_i && exp_ready;
        exp_wr  = 1'b0;
        exp_cmd = 1'b0;

        if ((mem_wr_error_i || mem_wr_underrun_i) &&
            (phase == P_FILL || phase == P_CMD || phase == P_FLUSH)) begin
            phase = P_ERR;
        end else begin
            case (phase)
                P_IDLE: if (start_i) begin
                    phase = P_FILL;
                    burst_bytes = 0;
                    cmds_model = 0;
                    acc.delete();
                end
                P_FILL: if (acc_now) begin
                    acc.push_back(in_data_i);
                    sent++;
                    burst_bytes++;
                    if (acc.size() == 4) begin
                        exp_words.push_back({acc[0], acc[1], acc[2], acc[3]});
                        acc.delete();
                        exp_wr = 1'b1;
                    end
                    if (burst_bytes == 256) begin
                        phase = P_CMD;
                        cmd_hold = cmdfull_len;
                    end
                end
                P_CMD: if (!mem_cmd_full_i) begin
                    exp_cmd = 1'b1;
                    burst_bytes = 0;
                    cmds_model++;
                    phase = (cmds_model * 256 == TOTAL) ? P_FLUSH : P_FILL;
                    flush_hold = flush_len;
                end
                P_FLUSH: if (mem_wr_empty_i && mem_cmd_empty_i) phase = P_DONE;
                default: ;
            endcase
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start_i = 1'b0; in_valid_i = 1'b0; mem_wr_full_i = 1'b0;
        mem_cmd_full_i = 1'b0; mem_wr_error_i = 1'b0; mem_wr_underrun_i = 1'b0;
        #1;
        n_tests++;
        if ({in_ready_o, mem_cmd_en_o, mem_wr_en_o, done_o, error_o} !== 5'b0 ||
            mem_wr_data_o !== 32'h0 || mem_cmd_byte_addr_o !== 30'h0 || progress_o !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_outputs rdy=%b cmd=%b wr=%b done=%b err=%b data=%h addr=%h prog=%h exp=all_zero",
                     in_ready_o, mem_cmd_en_o, mem_wr_en_o, done_o, error_o,
                     mem_wr_data_o, mem_cmd_byte_addr_o, progress_o);
        end
        n_tests++;
        if (mem_cmd_instr_o !== 3'b000 || mem_cmd_bl_o !== 6'd63 || mem_wr_mask_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL constants instr=%b bl=%0d mask=%b exp=000/63/0000",
                     mem_cmd_instr_o, mem_cmd_bl_o, mem_wr_mask_o);
        end
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to_done(input int budget);
        int k;
        k = 0;
        while (phase != P_DONE && phase != P_ERR && k < budget) begin
            run_cycle();
            k++;
        end
        repeat (2) run_cycle();
    endtask

    task automatic check_copy_end(input string name);
        n_tests++;
        if (done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done got=%b exp=1", name, done_o);
        end
        n_tests++;
        if (dut_wr != TOTAL / 4 || dut_cmds != BURSTS) begin
            n_fail++;
            $display("FAIL %s_counts wr=%0d cmds=%0d exp=%0d/%0d", name, dut_wr, dut_cmds, TOTAL / 4, BURSTS);
        end
        n_tests++;
        if (first_cmd_addr !== BASE) begin
            n_fail++;
            $display("FAIL %s_first_addr got=%h exp=%h", name, first_cmd_addr, BASE);
        end
    endtask

    task automatic test_reset();
        valid_pct = 100; wf_start = 0; wf_len = 0; cmdfull_len = 0; flush_len = 0;
        do_reset();
        repeat (8) run_cycle();
    endtask

    task automatic test_back_to_back();
        valid_pct = 100; wf_len = 0; cmdfull_len = 0; flush_len = 4;
        load_stream(1'b1);
        do_reset();
        start_req = 1'b1;
        run_to_done(4000);
        check_copy_end("b2b");
        n_tests++;
        if (first_data !== 32'h00010203 || last_data !== 32'hFCFDFEFF) begin
            n_fail++;
            $display("FAIL b2b_words first=%h last=%h exp=00010203/fcfdfeff", first_data, last_data);
        end
        start_req = 1'b1;
        repeat (5) run_cycle();
    endtask

    task automatic test_random_copy();
        valid_pct = 60; wf_len = 0; cmdfull_len = 0; flush_len = 7;
        load_stream(1'b0);
        do_reset();
        start_req = 1'b1;
        run_to_done(6000);
        check_copy_end("rand");
    endtask

    task automatic test_wr_full_stall();
        valid_pct = 100; cmdfull_len = 0; flush_len = 3;
        load_stream(1'b0);
        do_reset();
        start_req = 1'b1;
        wf_start = cyc + 8; wf_len = 10;
        run_to_done(4000);
        check_copy_end("wrfull");
        wf_len = 0;
    endtask

    task automatic test_cmd_full_stall();
        valid_pct = 90; wf_len = 0; cmdfull_len = 5; flush_len = 2;
        load_stream(1'b0);
        do_reset();
        start_req = 1'b1;
        run_to_done(5000);
        check_copy_end("cmdfull");
        cmdfull_len = 0;
    endtask

    task automatic test_error();
        int wr_before, cmd_before;
        valid_pct = 100; wf_len = 0; cmdfull_len = 0; flush_len = 0;
        load_stream(1'b0);
        do_reset();
        start_req = 1'b1;
        repeat (42) run_cycle();
        err_req = 1'b1;
        run_cycle();
        wr_before = dut_wr; cmd_before = dut_cmds;
        repeat (20) run_cycle();
        start_req = 1'b1;
        repeat (10) run_cycle();
        n_tests++;
        if (error_o !== 1'b1 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_status error=%b done=%b exp=1/0", error_o, done_o);
        end
        n_tests++;
        if (dut_wr != wr_before || dut_cmds != cmd_before) begin
            n_fail++;
            $display("FAIL err_quiet wr=%0d cmds=%0d exp=%0d/%0d", dut_wr, dut_cmds, wr_before, cmd_before);
        end
    endtask

    task automatic test_async_reset();
        valid_pct = 80; wf_len = 0; cmdfull_len = 0; flush_len = 2;
        load_stream(1'b0);
        do_reset();
        start_req = 1'b1;
        repeat (101) run_cycle();
        do_reset();
        start_req = 1'b1;
        run_to_done(5000);
        check_copy_end("arst");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_back_to_back();
        test_random_copy();
        test_wr_full_stall();
        test_cmd_full_stall();
        test_error();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
